bg_scroll_engine: RTL and testbench

Parametrised scrolling-background address engine for the Bosconian playfield. Each frame it keeps a wrapped X/Y scroll offset driven by the player direction and speed. Each pixel it turns DrawX/DrawY into a background ROM address and returns the ROM's palette index, aligned with a delayed blank. It sits between the VGA controller and the colour mixer and supports diagonal motion, variable speed and arbitrary (non-power-of-2) image sizes.

---
 rtl/bg_pkg.sv | 19 +
 rtl/bg_axis_offset.sv | 41 ++++
 rtl/bg_scroll_engine.sv | 127 ++++++++++++
 tb/tb_bg_scroll_engine.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/bg_pkg.sv
// Shared constants for the scrolling background engine: direction bit map,
// pixel pipeline depth and default playfield dimensions.
package bg_pkg;
  localparam int DIR_UP    = 3;
  localparam int DIR_DOWN  = 2;
  localparam int DIR_RIGHT = 1;
  localparam int DIR_LEFT  = 0;

  localparam int BG_LATENCY = 4;

  localparam int BG_IMG_W    = 640;
  localparam int BG_IMG_H    = 480;
  localparam int BG_SCREEN_W = 640;
  localparam int BG_SCREEN_H = 480;

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction
endpackage

// File: rtl/bg_axis_offset.sv
// One wrapping scroll accumulator: moves by speed_i per enabled tick,
// modulo MOD, with opposing inc/dec requests cancelling.
module bg_axis_offset #(
  parameter int MOD     = 640,
  parameter int W       = $clog2(MOD),
  parameter int SPEED_W = 3
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               en_i,
  input  logic               inc_i,
  input  logic               dec_i,
  input  logic [SPEED_W-1:0] speed_i,
  output logic [W-1:0]       off_o
);
  localparam int AW = ((W > SPEED_W) ? W : SPEED_W) + 1;
  localparam logic [AW-1:0] MODV = AW'(MOD);

  logic [W-1:0]  off_q, off_d;
  logic [AW-1:0] cur, spd, sum_raw, sum_w, dif_w;

  assign cur     = AW'(off_q);
  assign spd     = AW'(speed_i);
  assign sum_raw = cur + spd;
  assign sum_w   = (sum_raw >= MODV) ? sum_raw - MODV : sum_raw;
  // speed < MOD, so one conditional add covers the underflow.
  assign dif_w   = (cur < spd) ? cur + MODV - spd : cur - spd;

  always_comb begin
    off_d = off_q;
    if (en_i && inc_i && !dec_i)      off_d = W'(sum_w);
    else if (en_i && dec_i && !inc_i) off_d = W'(dif_w);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) off_q <= '0;
    else         off_q <= off_d;
  end

  assign off_o = off_q;
endmodule

// File: rtl/bg_scroll_engine.sv
// Scrolling background address engine: frame-rate wrapped offsets and a
// 4-stage pixel-to-ROM-address pipeline. Optional far layer: BG_PARALLAX_EN.
module bg_scroll_engine
  import bg_pkg::*;
#(
  parameter int IMG_W    = BG_IMG_W,
  parameter int IMG_H    = BG_IMG_H,
  parameter int SCREEN_W = BG_SCREEN_W,
  parameter int SCREEN_H = BG_SCREEN_H,
  parameter int ADDR_W   = 19,
  parameter int IDX_W    = 1,
  parameter int SPEED_W  = 3,
  localparam int XW      = $clog2(IMG_W),
  localparam int YW      = $clog2(IMG_H)
) (
  input  logic               vga_clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic [3:0]         direction,
  input  logic [SPEED_W-1:0] speed,
  input  logic               collided,
  input  logic [9:0]         DrawX,
  input  logic [9:0]         DrawY,
  input  logic               blank,
  output logic [ADDR_W-1:0]  rom_address,
  input  logic [IDX_W-1:0]   rom_q,
`ifdef BG_PARALLAX_EN
  output logic [ADDR_W-1:0]  rom_address_far,
  input  logic [IDX_W-1:0]   rom_q_far,
`endif
  output logic [IDX_W-1:0]   bg_index,
  output logic               bg_valid,
  output logic [XW-1:0]      x_offset,
  output logic [YW-1:0]      y_offset
);
`ifdef BG_PARALLAX_EN
  localparam int NL = 2;
`else
  localparam int NL = 1;
`endif
  localparam int SW = ((XW > 10) ? XW : 10) + 1;
  localparam int HW = ((YW > 10) ? YW : 10) + 1;

  logic tick_ok;
  logic [NL-1:0][XW-1:0]     xo, col_d, col_q;
  logic [NL-1:0][YW-1:0]     yo, row_d, row_q;
  logic [NL-1:0][ADDR_W-1:0] addr_d, addr_q;
  logic [BG_LATENCY:1]       vld_pipe;
  logic [IDX_W-1:0]          idx_d, idx_q;

  assign tick_ok = frame_tick & ~collided;

  bg_axis_offset #(.MOD(IMG_W), .W(XW), .SPEED_W(SPEED_W)) u_x (
    .clk_i(vga_clk), .reset_i(reset), .en_i(tick_ok),
    .inc_i(direction[DIR_RIGHT]), .dec_i(direction[DIR_LEFT]),
    .speed_i(speed), .off_o(xo[0])
  );
  bg_axis_offset #(.MOD(IMG_H), .W(YW), .SPEED_W(SPEED_W)) u_y (
    .clk_i(vga_clk), .reset_i(reset), .en_i(tick_ok),
    .inc_i(direction[DIR_DOWN]), .dec_i(direction[DIR_UP]),
    .speed_i(speed), .off_o(yo[0])
  );

`ifdef BG_PARALLAX_EN
  // Far layer moves at half rate: only on odd qualifying ticks.
  logic par_q;
  always_ff @(posedge vga_clk) begin
    if (reset)        par_q <= 1'b0;
    else if (tick_ok) par_q <= ~par_q;
  end

  bg_axis_offset #(.MOD(IMG_W), .W(XW), .SPEED_W(SPEED_W)) u_xf (
    .clk_i(vga_clk), .reset_i(reset), .en_i(tick_ok & par_q),
    .inc_i(direction[DIR_RIGHT]), .dec_i(direction[DIR_LEFT]),
    .speed_i(speed), .off_o(xo[1])
  );
  bg_axis_offset #(.MOD(IMG_H), .W(YW), .SPEED_W(SPEED_W)) u_yf (
    .clk_i(vga_clk), .reset_i(reset), .en_i(tick_ok & par_q),
    .inc_i(direction[DIR_DOWN]), .dec_i(direction[DIR_UP]),
    .speed_i(speed), .off_o(yo[1])
  );

  assign idx_d           = (rom_q != '0) ? rom_q : rom_q_far;
  assign rom_address_far = addr_q[1];
`else
  assign idx_d = rom_q;
`endif

  for (genvar l = 0; l < NL; l++) begin : g_layer
    logic [SW-1:0] cs;
    logic [HW-1:0] rs;
    // Screen never exceeds the image, so one conditional subtract wraps.
    assign cs        = SW'(DrawX) + SW'(xo[l]);
    assign rs        = HW'(DrawY) + HW'(yo[l]);
    assign col_d[l]  = (cs >= SW'(IMG_W)) ? XW'(cs - SW'(IMG_W)) : XW'(cs);
    assign row_d[l]  = (rs >= HW'(IMG_H)) ? YW'(rs - HW'(IMG_H)) : YW'(rs);
    assign addr_d[l] = ADDR_W'(row_q[l]) * ADDR_W'(IMG_W) + ADDR_W'(col_q[l]);
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      col_q    <= '0;
      row_q    <= '0;
      addr_q   <= '0;
      vld_pipe <= '0;
      idx_q    <= '0;
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      addr_q   <= addr_d;
      vld_pipe <= {vld_pipe[BG_LATENCY-1:1], blank};
      idx_q    <= idx_d;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (!reset && frame_tick)
      a_cfg: assert (int'(speed) < min2(IMG_W, IMG_H) &&
                     SCREEN_W <= IMG_W && SCREEN_H <= IMG_H);
  end

  assign rom_address = addr_q[0];
  assign bg_index    = idx_q;
  assign bg_valid    = vld_pipe[BG_LATENCY];
  assign x_offset    = xo[0];
  assign y_offset    = yo[0];
endmodule

// File: tb/tb_bg_scroll_engine.sv
// Directed bench for bg_scroll_engine with a synchronous ROM model.
module tb_bg_scroll_engine;
  logic        vga_clk = 1'b0;
  logic        reset = 1'b1, frame_tick = 1'b0, collided = 1'b0, blank = 1'b0;
  logic [3:0]  direction = 4'b0000;
  logic [2:0]  speed = 3'd0;
  logic [9:0]  DrawX = 10'd0, DrawY = 10'd0;
  logic [18:0] rom_address;
  logic        rom_q = 1'b0;
  logic        bg_index, bg_valid;
  logic [9:0]  x_offset;
  logic [8:0]  y_offset;
`ifdef BG_PARALLAX_EN
  logic [18:0] rom_address_far;
  logic        rom_q_far = 1'b0;
`endif

  int errs = 0;
  int checks = 0;

  always #5 vga_clk = ~vga_clk;

  bg_scroll_engine dut (
    .vga_clk(vga_clk), .reset(reset), .frame_tick(frame_tick),
    .direction(direction), .speed(speed), .collided(collided),
    .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .rom_address(rom_address), .rom_q(rom_q),
`ifdef BG_PARALLAX_EN
    .rom_address_far(rom_address_far), .rom_q_far(rom_q_far),
`endif
    .bg_index(bg_index), .bg_valid(bg_valid),
    .x_offset(x_offset), .y_offset(y_offset)
  );

  function automatic logic rom_word(input logic [18:0] a);
    return ~(a[0] ^ a[1] ^ a[3]);
  endfunction

  always @(posedge vga_clk) rom_q <= rom_word(rom_address);
`ifdef BG_PARALLAX_EN
  always @(posedge vga_clk) rom_q_far <= rom_address_far[0];
`endif

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge vga_clk);
      #1;
    end
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  initial begin
    step(2);
    chk("rst_x", int'(x_offset), 0);
    chk("rst_y", int'(y_offset), 0);
    chk("rst_addr", int'(rom_address), 0);
    chk("rst_idx", int'(bg_index), 0);
    chk("rst_vld", int'(bg_valid), 0);

    // first pixel through the pipeline
    reset = 1'b0; blank = 1'b1; DrawX = 10'd0; DrawY = 10'd0;
    step(2);
    chk("addr0_c2", int'(rom_address), 0);
    step(1);
    chk("vld_c3", int'(bg_valid), 0);
    step(1);
    chk("vld_c4", int'(bg_valid), 1);
    chk("idx_c4", int'(bg_index), 1);

    direction = 4'b0010; speed = 3'd1;
    tick(); tick(); tick();
    chk("x_right3", int'(x_offset), 3);
    DrawX = 10'd639;
    step(2);
    chk("addr_colwrap", int'(rom_address), 2);
    step(2);
    chk("idx_addr2", int'(bg_index), 0);

    // reset beats frame_tick
    reset = 1'b1; frame_tick = 1'b1;
    step();
    reset = 1'b0; frame_tick = 1'b0;
    chk("rst_over_tick_x", int'(x_offset), 0);

    direction = 4'b0001; speed = 3'd2;
    tick();
    chk("x_left_wrap", int'(x_offset), 638);
    direction = 4'b1000; speed = 3'd1;
    tick();
    chk("y_up_wrap", int'(y_offset), 479);
    chk("x_hold_on_y", int'(x_offset), 638);

    reset = 1'b1; step(); reset = 1'b0;
    direction = 4'b1001;
    tick();
    chk("diag_x", int'(x_offset), 639);
    chk("diag_y", int'(y_offset), 479);
    DrawX = 10'd0; DrawY = 10'd0;
    step(2);
    chk("addr_corner", int'(rom_address), 307199);

    collided = 1'b1; direction = 4'b0100;
    tick();
    collided = 1'b0;
    chk("collided_y", int'(y_offset), 479);
    direction = 4'b1100;
    tick();
    chk("cancel_y", int'(y_offset), 479);
    chk("cancel_x", int'(x_offset), 639);
    direction = 4'b0000;
    tick();
    chk("none_x", int'(x_offset), 639);
    direction = 4'b0010; speed = 3'd0;
    tick();
    chk("speed0_x", int'(x_offset), 639);
    speed = 3'd5;
    tick();
    chk("x_right_wrap5", int'(x_offset), 4);
    direction = 4'b0100; speed = 3'd3;
    tick();
    chk("y_down_wrap3", int'(y_offset), 2);

    // mid-line reset flushes the valid pipe
    reset = 1'b1; step(); reset = 1'b0;
    chk("flush_vld0", int'(bg_valid), 0);
    step(3);
    chk("flush_vld3", int'(bg_valid), 0);
    step(1);
    chk("flush_vld4", int'(bg_valid), 1);

`ifdef BG_PARALLAX_EN
    reset = 1'b1; step(); reset = 1'b0;
    direction = 4'b0010; speed = 3'd1;
    tick(); tick(); tick(); tick();
    chk("plx_near_x", int'(x_offset), 4);
    DrawX = 10'd1; DrawY = 10'd0;
    step(2);
    chk("plx_near_addr", int'(rom_address), 5);
    chk("plx_far_addr", int'(rom_address_far), 3);
    step(2);
    chk("plx_idx_far", int'(bg_index), 1);
    DrawX = 10'd2;
    step(4);
    chk("plx_idx_zero", int'(bg_index), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
